// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the ADC command responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_resp_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CHAN_W = 5;
    localparam int DROP_W     = 8;
    // Conversion counter width; covers the full 1..1023 latency range.
    localparam int CNT_W      = 10;

    localparam logic [ADC_DATA_W-1:0] ZERO_DATA = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adc_resp_pattern.sv
// 12-bit ramp generator used as a synthetic ADC sample source.
// Latency: ramp advances one edge after the advance strobe is seen.
// Backpressure: none; advance is a single-cycle strobe, wraps FFF->000.
module adc_resp_pattern
    import adc_resp_pkg::*;
(
    input  logic                  adc_clk,
    input  logic                  reset_n,
    input  logic                  advance,
    output logic [ADC_DATA_W-1:0] ramp
);

    // Ramp counter, wraps naturally at the data width.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp <= '0;
        end else if (advance) begin
            ramp <= ramp + ADC_DATA_W'(1);
        end
    end

endmodule

// File: rtl/adc_cmd_responder.sv
// ADC command responder: accepts one command, waits CONV_CYCLES, returns one tagged 12-bit response.
// Latency: response_valid registered at accept edge + CONV_CYCLES; next accept earliest at + CONV_CYCLES + 2.
// Backpressure: command_ready low while busy (drops counted, saturating); response has no backpressure.
// Build option: define ADC_RESP_PATTERN_EN to return an internal ramp instead of sample_in.
module adc_cmd_responder
    import adc_resp_pkg::*;
#(
    parameter int CONV_CYCLES = 20,
    parameter int MAX_CHAN    = 16
) (
    input  logic                  adc_clk,
    input  logic                  reset_n,
    input  logic                  command_valid,
    input  logic [ADC_CHAN_W-1:0] command_channel,
    output logic                  command_ready,
    input  logic [ADC_DATA_W-1:0] sample_in,
    output logic                  response_valid,
    output logic [ADC_CHAN_W-1:0] response_channel,
    output logic [ADC_DATA_W-1:0] response_data,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt
);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [ADC_CHAN_W-1:0]   chan_q;
    logic                    accept;
    logic                    resp_fire;
    logic [ADC_DATA_W-1:0]   src_data;

    assign command_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign accept        = command_valid && command_ready;

`ifdef ADC_RESP_PATTERN_EN
    logic unused_sample;
    assign unused_sample = ^sample_in;

    adc_resp_pattern u_pattern (
        .adc_clk (adc_clk),
        .reset_n (reset_n),
        .advance (resp_fire),
        .ramp    (src_data)
    );
`else
    assign src_data = sample_in;
`endif

    // State and conversion counter registers.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; resp_fire marks the edge that registers the result.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        resp_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (command_valid) begin
                    state_nxt = ST_CONV;
                    cnt_nxt   = CNT_W'(CONV_CYCLES - 1);
                end
            end
            ST_CONV: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    resp_fire = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Channel latched at accept; held for the whole conversion.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_q <= '0;
        end else if (accept) begin
            chan_q <= command_channel;
        end
    end

    // Response registers; channel/data hold their value between pulses.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            response_valid   <= 1'b0;
            response_channel <= '0;
            response_data    <= '0;
        end else begin
            response_valid <= resp_fire;
            if (resp_fire) begin
                response_channel <= chan_q;
                response_data    <= (int'(chan_q) <= MAX_CHAN) ? src_data : ZERO_DATA;
            end
        end
    end

    // Saturating count of cycles where a command was offered while busy.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (command_valid && !command_ready && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule
